// File: rtl/sumcmp_pkg.sv
// sumcmp_pkg -- shared definitions for the serial checksum/compare block.
//   Build option: SUMCMP_ENDAROUND_EN adds the FOLD state (ones-complement
//   end-around carry fold-in pass).
//   Contents: state enum, default width/channel-count constants, serial
//   full-adder cell used by the accumulator.

package sumcmp_pkg;

    localparam int SUMCMP_SUM_W_DEF = 12;
    localparam int SUMCMP_NCH_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2
`ifdef SUMCMP_ENDAROUND_EN
        ,
        ST_FOLD    = 2'd3
`endif
    } sumcmp_state_e;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] sumcmp_fa(input logic a, input logic b, input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
        return {co, s};
    endfunction

endpackage

// File: rtl/mdl_sumcmp_mch_if.sv
// mdl_sumcmp_mch_if -- control/data bundle of the serial checksum/compare block.
//   Build option: none (SUMCMP_ENDAROUND_EN only affects the top).
//   master modport: drives i_CEN_n, i_BDI, i_ACC_START/SHIFT/STOP, i_CH_SEL,
//                   i_REF_LD, i_CMP_START; observes o_BUSY, o_SUM, o_REF_LSB,
//                   o_CMP_DONE, o_SUMEQ_n.
//   slave modport:  the mirror image, used by mdl_sumcmp_mch.

interface mdl_sumcmp_mch_if
    import sumcmp_pkg::*;
#(
    parameter int SUM_W = SUMCMP_SUM_W_DEF,
    parameter int NCH   = SUMCMP_NCH_DEF,
    parameter int CH_W  = $clog2(NCH)
);
    logic             i_CEN_n;
    logic             i_BDI;
    logic             i_ACC_START;
    logic             i_ACC_SHIFT;
    logic             i_ACC_STOP;
    logic [CH_W-1:0]  i_CH_SEL;
    logic             i_REF_LD;
    logic             i_CMP_START;
    logic             o_BUSY;
    logic [SUM_W-1:0] o_SUM;
    logic             o_REF_LSB;
    logic             o_CMP_DONE;
    logic             o_SUMEQ_n;

    modport master (
        output i_CEN_n, i_BDI, i_ACC_START, i_ACC_SHIFT, i_ACC_STOP,
               i_CH_SEL, i_REF_LD, i_CMP_START,
        input  o_BUSY, o_SUM, o_REF_LSB, o_CMP_DONE, o_SUMEQ_n
    );

    modport slave (
        input  i_CEN_n, i_BDI, i_ACC_START, i_ACC_SHIFT, i_ACC_STOP,
               i_CH_SEL, i_REF_LD, i_CMP_START,
        output o_BUSY, o_SUM, o_REF_LSB, o_CMP_DONE, o_SUMEQ_n
    );

endinterface

// File: rtl/mdl_sumcmp_refbank.sv
// mdl_sumcmp_refbank -- NCH x SUM_W reference register file.
//   Build option: none.
//   Ports: i_MCLK/i_RST_n (sync active-low clear of every entry),
//          we/wr_ch/wr_data parallel write (caller qualifies we with enable),
//          rd_ch/rd_k -> rd_bit single-bit read for the serial compare,
//          lsb_ch -> lsb bit-0 tap.

module mdl_sumcmp_refbank
    import sumcmp_pkg::*;
#(
    parameter int SUM_W = SUMCMP_SUM_W_DEF,
    parameter int NCH   = SUMCMP_NCH_DEF,
    parameter int CH_W  = $clog2(NCH),
    parameter int BC_W  = $clog2(SUM_W)
) (
    input  logic             i_MCLK,
    input  logic             i_RST_n,
    input  logic             we,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [SUM_W-1:0] wr_data,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [BC_W-1:0]  rd_k,
    output logic             rd_bit,
    input  logic [CH_W-1:0]  lsb_ch,
    output logic             lsb
);

    logic [SUM_W-1:0] ref_q [NCH];

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            for (int i = 0; i < NCH; i++) begin
                ref_q[i] <= '0;
            end
        end else if (we) begin
            ref_q[wr_ch] <= wr_data;
        end
    end

    assign rd_bit = ref_q[rd_ch][rd_k];
    assign lsb    = ref_q[lsb_ch][0];

endmodule

// File: rtl/mdl_sumcmp_mch.sv
// mdl_sumcmp_mch -- bit-serial page checksum accumulator with a multi-channel
// reference bank and serial compare engine.
//   Build option: SUMCMP_ENDAROUND_EN -> ones-complement sum; wrap carry is
//   kept and a final carry is folded in by one extra SUM_W-cycle pass.
//   Ports: i_MCLK clock, i_RST_n synchronous active-low reset (honoured
//   regardless of i_CEN_n), bus (slave modport) carrying enable, serial data,
//   accumulate/compare controls, channel select and status outputs.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | sum valid, ref load / compare start accepted
//   ACCUM   | shifting serial words into the sum
//   COMPARE | rotating sum against ref[ch], one bit per enabled cycle
//   FOLD    | (end-around build) adding the leftover carry into the sum

module mdl_sumcmp_mch
    import sumcmp_pkg::*;
#(
    parameter int SUM_W = SUMCMP_SUM_W_DEF,
    parameter int NCH   = SUMCMP_NCH_DEF,
    parameter int CH_W  = $clog2(NCH)
) (
    input  logic            i_MCLK,
    input  logic            i_RST_n,
    mdl_sumcmp_mch_if.slave bus
);

    localparam int BC_W = $clog2(SUM_W);
    localparam int CC_W = $clog2(SUM_W + 1);

`ifdef SUMCMP_ENDAROUND_EN
    localparam logic KEEP_WRAP_CARRY = 1'b1;
`else
    localparam logic KEEP_WRAP_CARRY = 1'b0;
`endif

    sumcmp_state_e    state_q;
    sumcmp_state_e    state_nxt;
    sumcmp_state_e    exit_stop;
    sumcmp_state_e    exit_wrap;

    logic [SUM_W-1:0] sum_q;
    logic             carry_q;
    logic [BC_W-1:0]  bitcnt_q;
    logic             stop_pend_q;
    logic [CH_W-1:0]  cmp_ch_q;
    logic [CC_W-1:0]  cmp_cnt_q;
    logic             mis_q;
    logic             cmp_done_q;
    logic             sumeq_n_q;

    logic             do_clear;
    logic             do_shift;
    logic             set_pend;
    logic             do_cmp_init;
    logic             do_cmp_step;
    logic             do_cmp_end;
    logic             ref_we;

    logic             word_end;
    logic             fa_in;
    logic             fa_s;
    logic             fa_c;
    logic             ref_bit;

    assign word_end   = (bitcnt_q == BC_W'(SUM_W - 1));
    // FOLD shifts zeros so only the held carry is added.
    assign fa_in      = (state_q == ST_ACCUM) ? bus.i_BDI : 1'b0;
    assign {fa_c, fa_s} = sumcmp_fa(fa_in, sum_q[0], carry_q);

`ifdef SUMCMP_ENDAROUND_EN
    assign exit_stop = carry_q ? ST_FOLD : ST_IDLE;
    assign exit_wrap = fa_c    ? ST_FOLD : ST_IDLE;
`else
    assign exit_stop = ST_IDLE;
    assign exit_wrap = ST_IDLE;
`endif

    mdl_sumcmp_refbank #(
        .SUM_W (SUM_W),
        .NCH   (NCH),
        .CH_W  (CH_W),
        .BC_W  (BC_W)
    ) u_refbank (
        .i_MCLK  (i_MCLK),
        .i_RST_n (i_RST_n),
        .we      (ref_we),
        .wr_ch   (bus.i_CH_SEL),
        .wr_data (sum_q),
        .rd_ch   (cmp_ch_q),
        .rd_k    (BC_W'(cmp_cnt_q)),
        .rd_bit  (ref_bit),
        .lsb_ch  (bus.i_CH_SEL),
        .lsb     (bus.o_REF_LSB)
    );

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state_q <= ST_IDLE;
        end else if (!bus.i_CEN_n) begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        do_clear    = 1'b0;
        do_shift    = 1'b0;
        set_pend    = 1'b0;
        do_cmp_init = 1'b0;
        do_cmp_step = 1'b0;
        do_cmp_end  = 1'b0;
        ref_we      = 1'b0;
        if (!bus.i_CEN_n) begin
            // Load is independent of the state transition so a same-cycle
            // compare start reads the freshly written reference.
            ref_we = (state_q == ST_IDLE) && bus.i_REF_LD;
            if (bus.i_ACC_START) begin
                do_clear  = 1'b1;
                state_nxt = ST_ACCUM;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.i_CMP_START) begin
                            do_cmp_init = 1'b1;
                            state_nxt   = ST_COMPARE;
                        end
                    end
                    ST_ACCUM: begin
                        if (bus.i_ACC_STOP) begin
                            if (bitcnt_q == '0) begin
                                state_nxt = exit_stop;
                            end else begin
                                set_pend = 1'b1;
                            end
                        end else if (bus.i_ACC_SHIFT) begin
                            do_shift = 1'b1;
                            if (word_end && stop_pend_q) begin
                                state_nxt = exit_wrap;
                            end
                        end
                    end
                    ST_COMPARE: begin
                        // One extra cycle after the last bit publishes the result.
                        if (cmp_cnt_q == CC_W'(SUM_W)) begin
                            do_cmp_end = 1'b1;
                            state_nxt  = ST_IDLE;
                        end else begin
                            do_cmp_step = 1'b1;
                        end
                    end
`ifdef SUMCMP_ENDAROUND_EN
                    ST_FOLD: begin
                        do_shift = 1'b1;
                        if (word_end) begin
                            state_nxt = ST_IDLE;
                        end
                    end
`endif
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            bitcnt_q    <= '0;
            stop_pend_q <= 1'b0;
            cmp_ch_q    <= '0;
            cmp_cnt_q   <= '0;
            mis_q       <= 1'b0;
            cmp_done_q  <= 1'b0;
            sumeq_n_q   <= 1'b1;
        end else if (!bus.i_CEN_n) begin
            cmp_done_q <= 1'b0;
            if (do_clear) begin
                sum_q       <= '0;
                carry_q     <= 1'b0;
                bitcnt_q    <= '0;
                stop_pend_q <= 1'b0;
            end else begin
                if (set_pend) begin
                    stop_pend_q <= 1'b1;
                end
                if (do_shift) begin
                    sum_q <= {fa_s, sum_q[SUM_W-1:1]};
                    if (word_end) begin
                        bitcnt_q    <= '0;
                        carry_q     <= (KEEP_WRAP_CARRY && (state_q == ST_ACCUM)) ? fa_c : 1'b0;
                        stop_pend_q <= 1'b0;
                    end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                        carry_q  <= fa_c;
                    end
                end
                if (do_cmp_init) begin
                    cmp_ch_q  <= bus.i_CH_SEL;
                    cmp_cnt_q <= '0;
                    mis_q     <= 1'b0;
                end
                if (do_cmp_step) begin
                    mis_q     <= mis_q | (sum_q[0] ^ ref_bit);
                    sum_q     <= {sum_q[0], sum_q[SUM_W-1:1]};
                    cmp_cnt_q <= cmp_cnt_q + 1'b1;
                end
                if (do_cmp_end) begin
                    cmp_done_q <= 1'b1;
                    sumeq_n_q  <= mis_q;
                end
            end
        end
    end

    assign bus.o_BUSY     = (state_q != ST_IDLE);
    assign bus.o_SUM      = sum_q;
    assign bus.o_CMP_DONE = cmp_done_q;
    assign bus.o_SUMEQ_n  = sumeq_n_q;

endmodule
